// File: rtl/z80_decode_pkg.sv
// Shared decode types: prefix vector encoding, prefix opcodes and the
// prefix sequencer state enum.
package z80_decode_pkg;

    // {nIXY, IXY, XX, CB, ED} as consumed by the PLA decoder
    typedef logic [4:0] prefix_t;

    localparam prefix_t PFX_XX     = 5'b10100;
    localparam prefix_t PFX_IXY_XX = 5'b01100;
    localparam prefix_t PFX_CB     = 5'b10010;
    localparam prefix_t PFX_IXY_CB = 5'b01010;
    localparam prefix_t PFX_ED     = 5'b10001;
    localparam prefix_t PFX_IXY_ED = 5'b01001;

    localparam logic [7:0] OP_DD = 8'hDD;
    localparam logic [7:0] OP_FD = 8'hFD;
    localparam logic [7:0] OP_CB = 8'hCB;
    localparam logic [7:0] OP_ED = 8'hED;

    typedef enum logic [2:0] {
        S_OP,
        S_IXY,
        S_CB,
        S_ED,
        S_XCB_D,
        S_XCB_OP,
        S_EXEC,
        S_HALT
    } seq_state_t;

endpackage

// File: rtl/z80_prefix_sequencer.sv
// Z80 prefix sequencer: walks DD/FD/CB/ED prefix bytes, captures the
// indexed-CB displacement, and presents ir/prefix to the PLA decoder.
// Also owns the HALT state, where a NOP is re-issued on every M1.
module z80_prefix_sequencer
    import z80_decode_pkg::*;
#(
    parameter logic [7:0] HALT_OPCODE = 8'h76,
    parameter logic [7:0] NOP_OPCODE  = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       op_valid,
    input  logic [7:0] op_byte,
    input  logic       instr_done,
    input  logic       int_ack,
    output logic [7:0] ir,
    output logic [4:0] prefix,
    output logic       ir_valid,
    output logic       use_iy,
    output logic [7:0] disp,
    output logic       in_prefix,
    output logic       in_halt
);

    seq_state_t state_reg, state_next;
    logic [7:0] ir_reg, ir_next;
    prefix_t    prefix_reg, prefix_next;
    logic       ir_valid_reg, ir_valid_next;
    logic       use_iy_reg, use_iy_next;
    logic [7:0] disp_reg, disp_next;
    logic       in_halt_reg, in_halt_next;
    // ED reached through DD/FD selects the indexed ED prefix encoding
    logic       ed_ixy_reg, ed_ixy_next;

    // Effective state after instr_done / int_ack, from which a byte is decoded
    seq_state_t cur_state;
    logic       cur_is_prefix;

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= S_OP;
            ir_reg       <= NOP_OPCODE;
            prefix_reg   <= PFX_XX;
            ir_valid_reg <= 1'b0;
            use_iy_reg   <= 1'b0;
            disp_reg     <= 8'h00;
            in_halt_reg  <= 1'b0;
            ed_ixy_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ir_reg       <= ir_next;
            prefix_reg   <= prefix_next;
            ir_valid_reg <= ir_valid_next;
            use_iy_reg   <= use_iy_next;
            disp_reg     <= disp_next;
            in_halt_reg  <= in_halt_next;
            ed_ixy_reg   <= ed_ixy_next;
        end
    end

    // Next state: completion first, then interrupt acceptance, then byte decode
    always_comb begin
        state_next    = state_reg;
        ir_next       = ir_reg;
        prefix_next   = prefix_reg;
        ir_valid_next = ir_valid_reg;
        use_iy_next   = use_iy_reg;
        disp_next     = disp_reg;
        in_halt_next  = in_halt_reg;
        ed_ixy_next   = ed_ixy_reg;
        cur_state     = state_reg;

        // Retire the executing instruction; an unprefixed HALT parks the CPU
        if (state_reg == S_EXEC && instr_done) begin
            ir_valid_next = 1'b0;
            prefix_next   = PFX_XX;
            use_iy_next   = 1'b0;
            if (ir_reg == HALT_OPCODE && prefix_reg == PFX_XX) begin
                cur_state    = S_HALT;
                in_halt_next = 1'b1;
                ir_next      = NOP_OPCODE;
            end else begin
                cur_state = S_OP;
            end
        end

        // The NOP pulse in halt lasts one cycle unless another M1 arrives
        if (cur_state == S_HALT) begin
            ir_valid_next = 1'b0;
        end

        cur_is_prefix = (cur_state == S_IXY) || (cur_state == S_CB) ||
                        (cur_state == S_ED) || (cur_state == S_XCB_D) ||
                        (cur_state == S_XCB_OP);

        // Interrupts mid-prefix cannot be honoured and are dropped
        if (int_ack && !cur_is_prefix) begin
            in_halt_next = 1'b0;
            if (cur_state == S_HALT) begin
                cur_state = S_OP;
            end
        end

        state_next = cur_state;

        if (op_valid) begin
            case (cur_state)
                S_OP: begin
                    if (op_byte == OP_DD || op_byte == OP_FD) begin
                        state_next  = S_IXY;
                        use_iy_next = (op_byte == OP_FD);
                    end else if (op_byte == OP_CB) begin
                        state_next = S_CB;
                    end else if (op_byte == OP_ED) begin
                        state_next  = S_ED;
                        ed_ixy_next = 1'b0;
                    end else begin
                        ir_next       = op_byte;
                        prefix_next   = PFX_XX;
                        ir_valid_next = 1'b1;
                        state_next    = S_EXEC;
                    end
                end
                S_IXY: begin
                    if (op_byte == OP_DD || op_byte == OP_FD) begin
                        use_iy_next = (op_byte == OP_FD);
                    end else if (op_byte == OP_CB) begin
                        state_next = S_XCB_D;
                    end else if (op_byte == OP_ED) begin
                        state_next  = S_ED;
                        ed_ixy_next = 1'b1;
                    end else begin
                        ir_next       = op_byte;
                        prefix_next   = PFX_IXY_XX;
                        ir_valid_next = 1'b1;
                        state_next    = S_EXEC;
                    end
                end
                S_CB: begin
                    ir_next       = op_byte;
                    prefix_next   = PFX_CB;
                    ir_valid_next = 1'b1;
                    state_next    = S_EXEC;
                end
                S_ED: begin
                    ir_next       = op_byte;
                    prefix_next   = ed_ixy_reg ? PFX_IXY_ED : PFX_ED;
                    ir_valid_next = 1'b1;
                    state_next    = S_EXEC;
                end
                S_XCB_D: begin
                    disp_next  = op_byte;
                    state_next = S_XCB_OP;
                end
                S_XCB_OP: begin
                    ir_next       = op_byte;
                    prefix_next   = PFX_IXY_CB;
                    ir_valid_next = 1'b1;
                    state_next    = S_EXEC;
                end
                S_HALT: begin
                    ir_valid_next = 1'b1;
                end
                default: begin
                    // S_EXEC: fetches during execution are not ours to decode
                end
            endcase
        end
    end

    assign ir        = ir_reg;
    assign prefix    = prefix_reg;
    assign ir_valid  = ir_valid_reg;
    assign use_iy    = use_iy_reg;
    assign disp      = disp_reg;
    assign in_halt   = in_halt_reg;
    assign in_prefix = (state_reg == S_IXY) || (state_reg == S_CB) ||
                       (state_reg == S_ED) || (state_reg == S_XCB_D) ||
                       (state_reg == S_XCB_OP);

endmodule

// File: tb/tb_z80_prefix_sequencer.sv
// Directed bench for z80_prefix_sequencer: prefix chains, displacement
// capture, HALT handling, asynchronous reset and done/fetch collisions.
module tb_z80_prefix_sequencer;

    logic       clk;
    logic       reset;
    logic       op_valid;
    logic [7:0] op_byte;
    logic       instr_done;
    logic       int_ack;
    logic [7:0] ir;
    logic [4:0] prefix;
    logic       ir_valid;
    logic       use_iy;
    logic [7:0] disp;
    logic       in_prefix;
    logic       in_halt;

    int n_checks = 0;
    int n_fails  = 0;

    z80_prefix_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .op_valid   (op_valid),
        .op_byte    (op_byte),
        .instr_done (instr_done),
        .int_ack    (int_ack),
        .ir         (ir),
        .prefix     (prefix),
        .ir_valid   (ir_valid),
        .use_iy     (use_iy),
        .disp       (disp),
        .in_prefix  (in_prefix),
        .in_halt    (in_halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One clock with the given strobes; outputs sampled 1 time unit after the edge
    task automatic step(input logic v, input logic [7:0] b, input logic done, input logic ack);
        @(negedge clk);
        op_valid   = v;
        op_byte    = b;
        instr_done = done;
        int_ack    = ack;
        @(posedge clk);
        #1;
        op_valid   = 1'b0;
        instr_done = 1'b0;
        int_ack    = 1'b0;
        $display("step v=%0b byte=%h done=%0b ack=%0b -> ir=%h pfx=%b irv=%0b iy=%0b disp=%h inp=%0b halt=%0b",
                 v, b, done, ack, ir, prefix, ir_valid, use_iy, disp, in_prefix, in_halt);
    endtask

    task automatic op(input logic [7:0] b);
        step(1'b1, b, 1'b0, 1'b0);
    endtask

    task automatic done();
        step(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        reset      = 1'b1;
        op_valid   = 1'b0;
        op_byte    = 8'h00;
        instr_done = 1'b0;
        int_ack    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;

        // Reset values
        chk("rst_ir", ir, 8'h00);
        chk("rst_prefix", {3'b0, prefix}, 8'h14);
        chk("rst_ir_valid", {7'b0, ir_valid}, 8'h00);
        chk("rst_use_iy", {7'b0, use_iy}, 8'h00);
        chk("rst_disp", disp, 8'h00);
        chk("rst_in_prefix", {7'b0, in_prefix}, 8'h00);
        chk("rst_in_halt", {7'b0, in_halt}, 8'h00);

        // Plain opcode
        op(8'h3E);
        chk("ld_ir", ir, 8'h3E);
        chk("ld_prefix", {3'b0, prefix}, 8'h14);
        chk("ld_ir_valid", {7'b0, ir_valid}, 8'h01);
        // Fetches during execution are ignored
        op(8'hDD);
        chk("exec_ign_in_prefix", {7'b0, in_prefix}, 8'h00);
        chk("exec_ign_ir", ir, 8'h3E);
        done();
        chk("ld_done_ir_valid", {7'b0, ir_valid}, 8'h00);
        chk("ld_done_prefix", {3'b0, prefix}, 8'h14);

        // DD FD 21: last index prefix wins
        op(8'hDD);
        chk("ixy_dd_in_prefix", {7'b0, in_prefix}, 8'h01);
        chk("ixy_dd_use_iy", {7'b0, use_iy}, 8'h00);
        op(8'hFD);
        chk("ixy_fd_in_prefix", {7'b0, in_prefix}, 8'h01);
        op(8'h21);
        chk("ixy_ir", ir, 8'h21);
        chk("ixy_prefix", {3'b0, prefix}, 8'h0C);
        chk("ixy_use_iy", {7'b0, use_iy}, 8'h01);
        chk("ixy_in_prefix", {7'b0, in_prefix}, 8'h00);
        chk("ixy_ir_valid", {7'b0, ir_valid}, 8'h01);
        done();
        chk("ixy_done_use_iy", {7'b0, use_iy}, 8'h00);

        // FD CB 05 C6: indexed bit op with displacement
        op(8'hFD);
        chk("xcb_fd_in_prefix", {7'b0, in_prefix}, 8'h01);
        op(8'hCB);
        chk("xcb_cb_in_prefix", {7'b0, in_prefix}, 8'h01);
        op(8'h05);
        chk("xcb_d_in_prefix", {7'b0, in_prefix}, 8'h01);
        chk("xcb_d_ir_valid", {7'b0, ir_valid}, 8'h00);
        op(8'hC6);
        chk("xcb_disp", disp, 8'h05);
        chk("xcb_ir", ir, 8'hC6);
        chk("xcb_prefix", {3'b0, prefix}, 8'h0A);
        chk("xcb_use_iy", {7'b0, use_iy}, 8'h01);
        chk("xcb_in_prefix", {7'b0, in_prefix}, 8'h00);
        done();

        // ED B0
        op(8'hED);
        chk("ed_in_prefix", {7'b0, in_prefix}, 8'h01);
        op(8'hB0);
        chk("ed_ir", ir, 8'hB0);
        chk("ed_prefix", {3'b0, prefix}, 8'h11);
        done();

        // DD ED 4A
        op(8'hDD);
        op(8'hED);
        op(8'h4A);
        chk("ixy_ed_ir", ir, 8'h4A);
        chk("ixy_ed_prefix", {3'b0, prefix}, 8'h09);
        done();

        // CB 11 (plain CB page)
        op(8'hCB);
        op(8'h11);
        chk("cb_ir", ir, 8'h11);
        chk("cb_prefix", {3'b0, prefix}, 8'h12);
        done();

        // HALT
        op(8'h76);
        chk("halt_ir", ir, 8'h76);
        done();
        chk("halt_in_halt", {7'b0, in_halt}, 8'h01);
        chk("halt_ir_nop", ir, 8'h00);
        chk("halt_prefix", {3'b0, prefix}, 8'h14);
        chk("halt_ir_valid", {7'b0, ir_valid}, 8'h00);
        for (int i = 0; i < 3; i++) begin
            op(8'h00);
            chk($sformatf("halt_pulse%0d_hi", i), {7'b0, ir_valid}, 8'h01);
            chk($sformatf("halt_pulse%0d_halt", i), {7'b0, in_halt}, 8'h01);
            idle();
            chk($sformatf("halt_pulse%0d_lo", i), {7'b0, ir_valid}, 8'h00);
        end
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("halt_ack_in_halt", {7'b0, in_halt}, 8'h00);
        chk("halt_ack_ir_valid", {7'b0, ir_valid}, 8'h00);
        op(8'h3C);
        chk("post_halt_ir", ir, 8'h3C);
        chk("post_halt_prefix", {3'b0, prefix}, 8'h14);
        chk("post_halt_ir_valid", {7'b0, ir_valid}, 8'h01);
        done();

        // Asynchronous reset in the middle of an indexed-CB prefix
        op(8'hFD);
        op(8'hCB);
        op(8'h07);
        chk("pre_rst_disp", disp, 8'h07);
        chk("pre_rst_use_iy", {7'b0, use_iy}, 8'h01);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_in_prefix", {7'b0, in_prefix}, 8'h00);
        chk("arst_disp", disp, 8'h00);
        chk("arst_use_iy", {7'b0, use_iy}, 8'h00);
        chk("arst_ir", ir, 8'h00);
        chk("arst_prefix", {3'b0, prefix}, 8'h14);
        @(negedge clk);
        reset = 1'b0;

        // instr_done and a CB fetch in the same cycle
        op(8'h3E);
        step(1'b1, 8'hCB, 1'b1, 1'b0);
        chk("coll_ir_valid", {7'b0, ir_valid}, 8'h00);
        chk("coll_in_prefix", {7'b0, in_prefix}, 8'h01);
        chk("coll_prefix", {3'b0, prefix}, 8'h14);
        op(8'h01);
        chk("coll_cb_ir", ir, 8'h01);
        chk("coll_cb_prefix", {3'b0, prefix}, 8'h12);
        chk("coll_cb_ir_valid", {7'b0, ir_valid}, 8'h01);
        done();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
